// File: rtl/aqed_multi_checker.sv
// A-QED functional-consistency checker: re-issues one original write as NUM_DUP duplicates and compares the tagged results.
// Optional watchdog driving qed_hang is built only when AQED_TIMEOUT_EN is defined.
module aqed_multi_checker #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TAG_W   = 32,
  parameter int unsigned NUM_DUP = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              exec_dup,
  input  logic              wen_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  input  logic [TAG_W-1:0]  out_tag_in,
  input  logic [DATA_W-1:0] data_out_in,
  output logic              qed_done,
  output logic              qed_check,
  output logic              qed_hang
);
  localparam int unsigned IDX_W = (NUM_DUP > 1) ? $clog2(NUM_DUP) : 1;
  localparam int          ND    = int'(NUM_DUP);

  typedef enum logic [2:0] {IDLE, ORIG, DUP, WAIT, DONE} state_t;

  state_t             state;
  logic [TAG_W-1:0]   in_count;
  logic [TAG_W-1:0]   orig_tag;
  logic [DATA_W-1:0]  orig_data;
  logic [DATA_W-1:0]  orig_out;
  logic               orig_vld;
  logic               orig_cap;
  logic [TAG_W-1:0]   dup_tag [NUM_DUP];
  logic [DATA_W-1:0]  dup_out [NUM_DUP];
  logic [NUM_DUP-1:0] dup_vld;
  logic [NUM_DUP-1:0] dup_cap;
  logic [IDX_W-1:0]   dup_idx;

  logic               accept;
  logic               issue_orig;
  logic               issue_dup;
  logic               last_dup;
  logic               all_cap;
  logic               all_match;
  logic               cap_en;
  logic               orig_hit;
  logic               found;
  logic [NUM_DUP-1:0] dup_hit;

  // Issue decisions, write-data steering and capture matching for this cycle
  always_comb begin
    accept     = ~reset & clk_en & wen_in & ~flush;
    issue_orig = accept & exec_dup & (state == IDLE);
    issue_dup  = accept & exec_dup & ((state == ORIG) | (state == DUP));
    last_dup   = (dup_idx == IDX_W'(NUM_DUP - 1));
    data_out   = issue_dup ? orig_data : data_in;
    all_cap    = orig_cap & (&dup_cap);
    all_match  = 1'b1;
    for (int k = 0; k < ND; k++) begin
      if (dup_out[k] != orig_out) all_match = 1'b0;
    end
    cap_en   = clk_en & valid_out & (state != IDLE);
    orig_hit = cap_en & orig_vld & ~orig_cap & (out_tag_in == orig_tag);
    found    = orig_hit;
    dup_hit  = '0;
    // Only the lowest still-open issued slot with a matching tag captures
    for (int k = 0; k < ND; k++) begin
      if (cap_en & ~found & dup_vld[k] & ~dup_cap[k] & (out_tag_in == dup_tag[k])) begin
        dup_hit[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_count  <= '0;
      orig_tag  <= '1;
      orig_data <= '0;
      orig_out  <= '0;
      orig_vld  <= 1'b0;
      orig_cap  <= 1'b0;
      dup_vld   <= '0;
      dup_cap   <= '0;
      dup_idx   <= '0;
      qed_done  <= 1'b0;
      qed_check <= 1'b1;
      for (int k = 0; k < ND; k++) begin
        dup_tag[k] <= '1;
        dup_out[k] <= '0;
      end
    end else if (clk_en) begin
      if (accept) in_count <= in_count + TAG_W'(1);
      if (orig_hit) begin
        orig_out <= data_out_in;
        orig_cap <= 1'b1;
      end
      for (int k = 0; k < ND; k++) begin
        if (dup_hit[k]) begin
          dup_out[k] <= data_out_in;
          dup_cap[k] <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (issue_orig) begin
            orig_data <= data_in;
            orig_tag  <= in_count;
            orig_vld  <= 1'b1;
            state     <= ORIG;
          end
        end
        ORIG, DUP: begin
          if (issue_dup) begin
            dup_tag[dup_idx] <= in_count;
            dup_vld[dup_idx] <= 1'b1;
            dup_idx          <= dup_idx + IDX_W'(1);
            state            <= last_dup ? WAIT : DUP;
          end
        end
        WAIT: begin
          if (all_cap) begin
            state     <= DONE;
            qed_done  <= 1'b1;
            qed_check <= all_match;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AQED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_count;

  // Watchdog counts enabled cycles spent waiting for results; hang is sticky
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_count <= '0;
      qed_hang <= 1'b0;
    end else if (clk_en) begin
      if (issue_dup & last_dup) begin
        wd_count <= '0;
      end else if ((state == WAIT) & ~qed_hang) begin
        wd_count <= wd_count + WD_W'(1);
        if (wd_count == WD_W'(TIMEOUT - 1)) qed_hang <= 1'b1;
      end
    end
  end
`else
  assign qed_hang = 1'b0;
`endif

endmodule

// File: tb/tb_aqed_multi_checker.sv
// Bench for aqed_multi_checker: directed vector table, hand sequences and random stimulus against a slot-based reference model.
module tb_aqed_multi_checker;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int ND = 3;
  localparam int TO = 8;
`ifdef AQED_TIMEOUT_EN
  localparam bit HANG_EN = 1'b1;
`else
  localparam bit HANG_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          clk_en;
  logic          flush;
  logic          exec_dup;
  logic          wen_in;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [TW-1:0] out_tag_in;
  logic [DW-1:0] data_out_in;
  logic          qed_done;
  logic          qed_check;
  logic          qed_hang;

  aqed_multi_checker #(
    .DATA_W (DW),
    .TAG_W  (TW),
    .NUM_DUP(ND),
    .TIMEOUT(TO)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .flush      (flush),
    .exec_dup   (exec_dup),
    .wen_in     (wen_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .out_tag_in (out_tag_in),
    .data_out_in(data_out_in),
    .qed_done   (qed_done),
    .qed_check  (qed_check),
    .qed_hang   (qed_hang)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] last_dout;

  // Reference model: slot 0 is the original, slots 1..ND the duplicates
  int          m_cnt;
  int          m_iss;
  logic [DW-1:0] m_orig;
  int          m_tag [ND+1];
  bit          m_cap [ND+1];
  logic [DW-1:0] m_out [ND+1];
  bit          m_done;
  bit          m_hang;
  int          m_wait;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_iss = 0; m_orig = '0; m_done = 0; m_hang = 0; m_wait = 0;
    for (int i = 0; i <= ND; i++) begin
      m_tag[i] = -1; m_cap[i] = 0; m_out[i] = '0;
    end
  endtask

  function automatic logic [DW-1:0] model_dout(input logic r, e, f, w, x, input logic [DW-1:0] d);
    if (!r && e && w && !f && x && m_iss >= 1 && m_iss <= ND) return m_orig;
    return d;
  endfunction

  task automatic model_edge(input logic r, e, f, w, x, input logic [DW-1:0] d,
                            input logic v, input logic [TW-1:0] t, input logic [DW-1:0] o);
    bit waiting;
    bit allc;
    if (r) begin
      model_reset();
    end else if (e) begin
      waiting = (m_iss == ND + 1) && !m_done;
      allc = 1;
      for (int i = 0; i <= ND; i++) allc &= m_cap[i];
      if (m_iss >= 1 && v) begin
        for (int i = 0; i < m_iss; i++) begin
          if (!m_cap[i] && m_tag[i] == int'(t)) begin
            m_cap[i] = 1; m_out[i] = o;
            break;
          end
        end
      end
      if (waiting) begin
        m_wait++;
        if (m_wait >= TO) m_hang = 1;
        if (allc) m_done = 1;
      end
      if (w && !f) begin
        if (x && m_iss <= ND) begin
          if (m_iss == 0) m_orig = d;
          m_tag[m_iss] = m_cnt;
          m_iss++;
          if (m_iss == ND + 1) m_wait = 0;
        end
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  function automatic bit model_check();
    if (!m_done) return 1'b1;
    for (int i = 1; i <= ND; i++) if (m_out[i] != m_out[0]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive, check combinational data_out, clock, check registered outputs
  task automatic step(input logic r, e, f, w, x, input logic [DW-1:0] d,
                      input logic v, input logic [TW-1:0] t, input logic [DW-1:0] o);
    reset = r; clk_en = e; flush = f; wen_in = w; exec_dup = x; data_in = d;
    valid_out = v; out_tag_in = t; data_out_in = o;
    #1;
    chk("data_out", 32'(data_out), 32'(model_dout(r, e, f, w, x, d)));
    last_dout = data_out;
    @(posedge clk);
    model_edge(r, e, f, w, x, d, v, t, o);
    #1;
    chk("qed_done", 32'(qed_done), 32'(m_done));
    chk("qed_check", 32'(qed_check), 32'(model_check()));
    chk("qed_hang", 32'(qed_hang), HANG_EN ? 32'(m_hang) : 32'd0);
  endtask

  task automatic rst();                               step(1, 1, 0, 0, 0, '0, 0, '0, '0); endtask
  task automatic wr(input logic x, input logic [DW-1:0] d); step(0, 1, 0, 1, x, d, 0, '0, '0); endtask
  task automatic ret(input logic [TW-1:0] t, input logic [DW-1:0] o); step(0, 1, 0, 0, 0, '0, 1, t, o); endtask
  task automatic idle();                              step(0, 1, 0, 0, 0, '0, 0, '0, '0); endtask

  typedef struct {
    logic r, e, f, w, x;
    logic [DW-1:0] d;
    logic v;
    logic [TW-1:0] t;
    logic [DW-1:0] o;
    logic [DW-1:0] exp_dout;
    logic exp_done;
    logic exp_chk;
  } vec_t;

  vec_t tbl [14];

  logic rr, re, rf, rw, rx, rv;
  logic [DW-1:0] rd, ro;
  logic [TW-1:0] rt;

  initial begin
    reset = 1; clk_en = 0; flush = 0; exec_dup = 0; wen_in = 0; data_in = '0;
    valid_out = 0; out_tag_in = '0; data_out_in = '0;
    model_reset();

    //          r  e  f  w  x  d         v  t      o          dout      done chk
    tbl[0]  = '{1, 1, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1};
    tbl[1]  = '{0, 1, 0, 1, 1, 16'h1234, 0, 8'h00, 16'h0000, 16'h1234, 0, 1};
    tbl[2]  = '{0, 1, 0, 1, 0, 16'h1111, 0, 8'h00, 16'h0000, 16'h1111, 0, 1};
    tbl[3]  = '{0, 1, 0, 1, 1, 16'h2222, 0, 8'h00, 16'h0000, 16'h1234, 0, 1};
    tbl[4]  = '{0, 1, 0, 1, 1, 16'h3333, 1, 8'h00, 16'h0005, 16'h1234, 0, 1};
    tbl[5]  = '{0, 1, 0, 1, 1, 16'h4444, 1, 8'h03, 16'h0005, 16'h1234, 0, 1};
    tbl[6]  = '{0, 1, 0, 0, 0, 16'h0000, 1, 8'h04, 16'h0006, 16'h0000, 0, 1};
    tbl[7]  = '{0, 1, 1, 1, 1, 16'h0077, 1, 8'h02, 16'h0005, 16'h0077, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 1, 0};
    tbl[9]  = '{0, 1, 0, 1, 1, 16'h9999, 0, 8'h00, 16'h0000, 16'h9999, 1, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 16'h0001, 0, 8'h00, 16'h0000, 16'h0001, 1, 0};
    tbl[11] = '{1, 1, 0, 0, 0, 16'h0000, 0, 8'h00, 16'h0000, 16'h0000, 0, 1};
    tbl[12] = '{0, 1, 0, 1, 1, 16'hABCD, 0, 8'h00, 16'h0000, 16'hABCD, 0, 1};
    tbl[13] = '{0, 1, 0, 1, 1, 16'h0BBB, 1, 8'h00, 16'h0007, 16'hABCD, 0, 1};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].f, tbl[i].w, tbl[i].x, tbl[i].d, tbl[i].v, tbl[i].t, tbl[i].o);
      chk($sformatf("tbl%0d_dout", i), 32'(last_dout), 32'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_done", i), 32'(qed_done), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_check", i), 32'(qed_check), 32'(tbl[i].exp_chk));
    end

    // Flushed and clock-gated writes do not consume tags; out-of-order and repeated results
    rst();
    wr(1, 16'h1234);
    step(0, 1, 1, 1, 1, 16'h0055, 0, '0, '0);
    step(0, 0, 0, 1, 1, 16'h0056, 0, '0, '0);
    wr(1, 16'h0066);
    chk("ooo_dup_data", 32'(last_dout), 32'h1234);
    wr(1, 16'h0067);
    wr(1, 16'h0068);
    ret(8'd2, 16'hABCD);
    ret(8'd0, 16'hABCD);
    ret(8'd0, 16'h1111);
    ret(8'd1, 16'hABCD);
    ret(8'd3, 16'hABCD);
    idle();
    chk("ooo_done", 32'(qed_done), 32'd1);
    chk("ooo_check", 32'(qed_check), 32'd1);

    // Reset while waiting discards captured results and restarts tags at 0
    rst();
    wr(1, 16'h0042);
    for (int i = 0; i < ND; i++) wr(1, 16'h0000);
    ret(8'd0, 16'h0009);
    rst();
    chk("rst_done", 32'(qed_done), 32'd0);
    chk("rst_check", 32'(qed_check), 32'd1);
    for (int i = 0; i <= ND; i++) wr(1, 16'h0100);
    for (int i = 0; i <= ND; i++) ret(8'(i), 16'h0009);
    idle();
    chk("rst_retag_done", 32'(qed_done), 32'd1);

    // Watchdog: counts only enabled cycles in WAIT; late completion still finishes
    rst();
    for (int i = 0; i <= ND; i++) wr(1, 16'h0200);
    for (int i = 0; i < TO - 1; i++) idle();
    step(0, 0, 0, 0, 0, '0, 0, '0, '0);
    chk("hang_before", 32'(qed_hang), 32'd0);
    idle();
    chk("hang_after", 32'(qed_hang), 32'(HANG_EN));
    for (int i = 0; i <= ND; i++) ret(8'(i), 16'h0003);
    idle();
    chk("late_done", 32'(qed_done), 32'd1);
    chk("late_hang", 32'(qed_hang), 32'(HANG_EN));

    // Random traffic against the model
    for (int run = 0; run < 20; run++) begin
      rst();
      for (int c = 0; c < 50; c++) begin
        rr = ($urandom_range(0, 49) == 0);
        re = ($urandom_range(0, 9) < 8);
        rf = ($urandom_range(0, 6) == 0);
        rw = ($urandom_range(0, 9) < 6);
        rx = 1'($urandom_range(0, 1));
        rd = 16'($urandom);
        rv = ($urandom_range(0, 9) < 6);
        rt = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
        ro = ($urandom_range(0, 5) == 0) ? 16'h0006 : 16'h0005;
        step(rr, re, rf, rw, rx, rd, rv, rt, ro);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
